// File: rtl/mem_bckdr_arbiter_if.sv
// rtl/mem_bckdr_arbiter_if.sv - requester and memory backdoor bundle for mem_bckdr_arbiter
interface mem_bckdr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*4-1:0]      req_len;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        wdata_ack;
  logic [DATA_W-1:0]         rdata;
  logic [NUM_REQ-1:0]        rdata_valid;
  logic [NUM_REQ-1:0]        done;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;
  logic                      mem_data_oe;
  logic                      mem_write;
  logic                      mem_read;
  logic [DATA_W-1:0]         mem_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_len, wdata, mem_rdata,
    input  grant, wdata_ack, rdata, rdata_valid, done,
    input  mem_addr, mem_data, mem_data_oe, mem_write, mem_read
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata, mem_rdata,
    output grant, wdata_ack, rdata, rdata_valid, done,
    output mem_addr, mem_data, mem_data_oe, mem_write, mem_read
  );
endinterface

// File: rtl/mem_bckdr_arbiter.sv
// rtl/mem_bckdr_arbiter.sv - round-robin burst arbiter onto the memory backdoor port
// Read bursts are built only when MEM_BCKDR_READ_EN is defined; otherwise every burst is a write.
module mem_bckdr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 10
) (
  input logic            wb_clk,
  input logic            wb_rst,
  mem_bckdr_arbiter_if.slave bus
);
  localparam int LEN_W = 4;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t             state, next_state;
  logic [IDX_W-1:0]   g_q, rr_q, pick;
  logic               pick_found, pick_wr;
  logic [LEN_W-1:0]   pick_len, pick_len_eff;
  logic [ADDR_W-1:0]  base_q;
  logic               wr_q;
  logic [LEN_W-1:0]   len_q, beat_q;
  logic               last_beat;
  logic [NUM_REQ-1:0] rvalid_q;

  // Scan downward so the lowest offset from the rr pointer is the one left standing.
  always_comb begin
    int idx;
    pick       = '0;
    pick_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        pick       = IDX_W'(idx);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_len = bus.req_len[int'(pick)*LEN_W +: LEN_W];
    if (pick_len == '0)
      pick_len_eff = LEN_W'(1);
    else if (pick_len > MAX_LEN)
      pick_len_eff = MAX_LEN;
    else
      pick_len_eff = pick_len;
`ifdef MEM_BCKDR_READ_EN
    pick_wr = bus.req_write[pick];
`else
    pick_wr = 1'b1;
`endif
  end

  assign last_beat = (beat_q == len_q - LEN_W'(1));

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state    <= IDLE;
      g_q      <= '0;
      rr_q     <= '0;
      base_q   <= '0;
      wr_q     <= 1'b0;
      len_q    <= '0;
      beat_q   <= '0;
      rvalid_q <= '0;
    end else begin
      state    <= next_state;
      rvalid_q <= '0;
      case (state)
        IDLE: if (pick_found) begin
          g_q    <= pick;
          base_q <= bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
          wr_q   <= pick_wr;
          len_q  <= pick_len_eff;
          beat_q <= '0;
        end
        BURST: begin
          if (!wr_q) rvalid_q[g_q] <= 1'b1;
          if (!last_beat) beat_q <= beat_q + LEN_W'(1);
        end
        DONE: rr_q <= (g_q == LAST_IDX) ? '0 : g_q + IDX_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_found) next_state = BURST;
      BURST:   if (last_beat) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.grant       = '0;
    bus.wdata_ack   = '0;
    bus.done        = '0;
    bus.mem_addr    = '0;
    bus.mem_data    = '0;
    bus.mem_data_oe = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_read    = 1'b0;
    case (state)
      BURST: begin
        bus.grant[g_q] = 1'b1;
        bus.mem_addr   = base_q + ADDR_W'(beat_q);
        if (wr_q) begin
          bus.mem_write      = 1'b1;
          bus.mem_data_oe    = 1'b1;
          bus.mem_data       = bus.wdata[int'(g_q)*DATA_W +: DATA_W];
          bus.wdata_ack[g_q] = 1'b1;
        end else begin
`ifdef MEM_BCKDR_READ_EN
          bus.mem_read = 1'b1;
`endif
        end
      end
      DONE: begin
        bus.grant[g_q] = 1'b1;
        bus.done[g_q]  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MEM_BCKDR_READ_EN
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata       = (|rvalid_q) ? bus.mem_rdata : '0;
`else
  assign bus.rdata_valid = '0;
  assign bus.rdata       = '0;
  logic unused_rd;
  assign unused_rd = ^{bus.req_write, bus.mem_rdata, rvalid_q};
`endif
endmodule

// File: tb/tb_mem_bckdr_arbiter.sv
// tb/tb_mem_bckdr_arbiter.sv - scoreboard bench for mem_bckdr_arbiter
module tb_mem_bckdr_arbiter;
  localparam int NUM_REQ   = 2;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 10;

  logic wb_clk = 1'b0;
  logic wb_rst;
  always #5 wb_clk = ~wb_clk;

  mem_bckdr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_bckdr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .wb_clk(wb_clk),
    .wb_rst(wb_rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          wr;
  } beat_t;

  int checks = 0;
  int failures = 0;
  int exp_rr = 0;
  beat_t beat_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem [0:255];
  logic [31:0] mem_rdata_r;

  always @(posedge wb_clk) if (bus.mem_read) mem_rdata_r <= mem[bus.mem_addr[7:0]];
  assign bus.mem_rdata = mem_rdata_r;

  task automatic next_cycle();
    @(posedge wb_clk); #1;
    @(negedge wb_clk);
  endtask

  task automatic do_burst(input int r, input bit wr, input logic [31:0] addr,
                          input logic [3:0] len, input logic [31:0] d0);
    int len_eff, k, beats;
    bit eff_wr, pend_adv, finished;
    logic [31:0] nxt, a;
    beat_t e;
    logic [31:0] er;
    len_eff = (len == 0) ? 1 : (int'(len) > MAX_BURST) ? MAX_BURST : int'(len);
`ifdef MEM_BCKDR_READ_EN
    eff_wr = wr;
`else
    eff_wr = 1'b1;
`endif
    for (int i = 0; i < len_eff; i++) begin
      a = addr + 32'(i);
      beat_q.push_back('{a, d0 + 32'(i), eff_wr});
      if (!eff_wr) rd_q.push_back(mem[a[7:0]]);
    end
    @(negedge wb_clk);
    bus.req_valid[r] = 1'b1;
    bus.req_write[r] = wr;
    bus.req_addr[r*32 +: 32] = addr;
    bus.req_len[r*4 +: 4] = len;
    bus.wdata[r*32 +: 32] = d0;
    nxt = d0; k = 0; beats = 0; finished = 0; pend_adv = 0;
    while (!finished && k < 30) begin
      @(posedge wb_clk); #1;
      if (pend_adv) begin
        nxt = nxt + 1;
        bus.wdata[r*32 +: 32] = nxt;
        pend_adv = 0;
      end
      @(negedge wb_clk);
      k++;
      if (k == 1) begin
        checks++;
        if (bus.grant !== NUM_REQ'(1 << r)) begin
          failures++; $display("FAIL first_grant r=%0d got=%b exp=%b", r, bus.grant, NUM_REQ'(1 << r));
        end
      end
      if (bus.mem_write || bus.mem_read) begin
        beats++;
        checks++;
        if (beat_q.size() == 0) begin
          failures++; $display("FAIL extra_beat cycle=%0d got=beat exp=none", k);
        end else begin
          e = beat_q.pop_front();
          if (bus.mem_addr !== e.addr || bus.mem_write !== e.wr || bus.mem_data_oe !== e.wr ||
              bus.mem_read !== !e.wr || (e.wr && bus.mem_data !== e.data) || k != beats) begin
            failures++;
            $display("FAIL beat cycle=%0d got addr=%h data=%h wr=%b rd=%b oe=%b exp addr=%h data=%h wr=%b beat_cycle=%0d",
                     k, bus.mem_addr, bus.mem_data, bus.mem_write, bus.mem_read, bus.mem_data_oe,
                     e.addr, e.data, e.wr, beats);
          end
        end
      end
      if (bus.rdata_valid[r]) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++; $display("FAIL extra_rdata cycle=%0d got=%h exp=none", k, bus.rdata);
        end else begin
          er = rd_q.pop_front();
          if (bus.rdata !== er) begin
            failures++; $display("FAIL rdata cycle=%0d got=%h exp=%h", k, bus.rdata, er);
          end
        end
      end
      if (bus.wdata_ack[r]) pend_adv = 1;
      if (bus.done[r]) begin
        finished = 1;
        checks++;
        if (k != len_eff + 1 || bus.grant !== NUM_REQ'(1 << r)) begin
          failures++; $display("FAIL done_cycle got=%0d grant=%b exp=%0d grant=%b", k, bus.grant, len_eff + 1, NUM_REQ'(1 << r));
        end
      end
    end
    bus.req_valid[r] = 1'b0;
    checks++;
    if (!finished) begin
      failures++; $display("FAIL burst_timeout got=no_done exp=done");
    end
    checks++;
    if (beats != len_eff || beat_q.size() != 0 || rd_q.size() != 0) begin
      failures++; $display("FAIL beat_count got=%0d exp=%0d left=%0d", beats, len_eff, beat_q.size() + rd_q.size());
    end
    beat_q.delete();
    rd_q.delete();
    exp_rr = (r + 1) % NUM_REQ;
    next_cycle();
    checks++;
    if (bus.grant !== '0 || bus.mem_addr !== '0 || bus.mem_data !== '0 || bus.mem_write !== 1'b0 ||
        bus.done !== '0 || bus.rdata_valid !== '0 || bus.wdata_ack !== '0) begin
      failures++; $display("FAIL idle_outputs got grant=%b addr=%h data=%h exp=all_zero", bus.grant, bus.mem_addr, bus.mem_data);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_len = '0; bus.wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    wb_rst = 1'b1;
    repeat (3) @(negedge wb_clk);
    checks++;
    if (bus.grant !== '0 || bus.done !== '0 || bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 ||
        bus.mem_addr !== '0 || bus.mem_data_oe !== 1'b0 || bus.rdata_valid !== '0 || bus.wdata_ack !== '0) begin
      failures++; $display("FAIL reset_state got grant=%b addr=%h wr=%b exp=all_zero", bus.grant, bus.mem_addr, bus.mem_write);
    end
    wb_rst = 1'b0;
    exp_rr = 0;
  endtask

  task automatic test_alternate();
    int k, ngrants, last_done, exp_g;
    logic [NUM_REQ-1:0] prev;
    @(negedge wb_clk);
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.req_write[r] = 1'b1;
      bus.req_addr[r*32 +: 32] = 32'h200 + 32'(r * 16);
      bus.req_len[r*4 +: 4] = 4'd2;
    end
    bus.req_valid = 2'b11;
    exp_g = exp_rr; k = 0; ngrants = 0; last_done = -1; prev = '0;
    while (k < 40 && !(ngrants == 4 && last_done == k)) begin
      next_cycle();
      k++;
      checks++;
      if ($countones(bus.grant) > 1) begin
        failures++; $display("FAIL one_hot cycle=%0d got=%b exp=onehot", k, bus.grant);
      end
      if (prev == '0 && bus.grant != '0) begin
        ngrants++;
        checks++;
        if (bus.grant !== NUM_REQ'(1 << exp_g) || (last_done >= 0 && k - last_done != 2)) begin
          failures++; $display("FAIL alt_grant cycle=%0d got=%b gap=%0d exp=%b gap=2", k, bus.grant, k - last_done, NUM_REQ'(1 << exp_g));
        end
        exp_g = (exp_g + 1) % NUM_REQ;
      end
      if (bus.done != '0) last_done = k;
      prev = bus.grant;
    end
    bus.req_valid = '0;
    checks++;
    if (ngrants != 4) begin
      failures++; $display("FAIL alt_count got=%0d exp=4", ngrants);
    end
    exp_rr = exp_g;
    repeat (2) next_cycle();
  endtask

  task automatic test_read();
    mem[8'h20] = 32'h11; mem[8'h21] = 32'h22; mem[8'h22] = 32'h33;
    do_burst(1, 1'b0, 32'h20, 4'd3, 32'hD0);
  endtask

  task automatic test_reset_mid();
    @(negedge wb_clk);
    bus.req_valid[0] = 1'b1;
    bus.req_write[0] = 1'b1;
    bus.req_addr[31:0] = 32'h300;
    bus.req_len[3:0] = 4'd10;
    bus.wdata[31:0] = 32'hC0;
    repeat (5) next_cycle();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h304) begin
      failures++; $display("FAIL mid_beat4 got wr=%b addr=%h exp wr=1 addr=00000304", bus.mem_write, bus.mem_addr);
    end
    wb_rst = 1'b1;
    #1;
    checks++;
    if (bus.grant !== '0 || bus.mem_write !== 1'b0 || bus.mem_addr !== '0 || bus.mem_data !== '0 ||
        bus.mem_data_oe !== 1'b0 || bus.wdata_ack !== '0 || bus.done !== '0) begin
      failures++; $display("FAIL async_reset got grant=%b wr=%b addr=%h exp=all_zero", bus.grant, bus.mem_write, bus.mem_addr);
    end
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      checks++;
      if (bus.done !== '0) begin
        failures++; $display("FAIL reset_no_done got=%b exp=00", bus.done);
      end
    end
    wb_rst = 1'b0;
    bus.req_len = {4'd1, 4'd1};
    bus.req_valid = 2'b11;
    next_cycle();
    checks++;
    if (bus.grant !== 2'b01) begin
      failures++; $display("FAIL post_reset_grant got=%b exp=01", bus.grant);
    end
    bus.req_valid = '0;
    repeat (5) next_cycle();
  endtask

  initial begin
    test_reset();
    do_burst(0, 1'b1, 32'h100, 4'd10, 32'hA0);
    test_alternate();
    test_read();
    do_burst(0, 1'b1, 32'hFFFF_FFFE, 4'd4, 32'h5000);
    do_burst(1, 1'b1, 32'h40, 4'd0, 32'h70);
    do_burst(0, 1'b1, 32'h80, 4'd15, 32'h90);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
